// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: access width encoding,
// responder FSM states and the alignment rule used by both store and load paths.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        MEM_WIDTH_BYTE = 2'd0,
        MEM_WIDTH_HALF = 2'd1,
        MEM_WIDTH_WORD = 2'd2
    } mem_width_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } resp_state_e;

    // Latency counter width; holds LATENCY-1 for LATENCY up to 15.
    localparam int unsigned CNT_W = 4;

    // Halves must be 2-byte aligned; words (and the unused encoding, which is
    // treated as a word everywhere) must be 4-byte aligned.
    function automatic logic is_misaligned(input mem_width_e width,
                                           input logic [1:0] addr_lo);
        case (width)
            MEM_WIDTH_BYTE: return 1'b0;
            MEM_WIDTH_HALF: return addr_lo[0];
            default:        return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_extract.sv
// Load-path lane extraction: selects the byte/half/word lane from a memory
// word by byte offset and sign- or zero-extends it to 32 bits.
module mem_lane_extract
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  mem_width_e  width,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [31:0] shifted;

    // Right-align the addressed lane, then extend it according to width.
    always_comb begin
        shifted = word >> {byte_off, 3'b000};
        case (width)
            MEM_WIDTH_BYTE: result = {{24{~is_unsigned & shifted[7]}},  shifted[7:0]};
            MEM_WIDTH_HALF: result = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default:        result = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: accepts one load/store, commits
// stores immediately, and returns a response LATENCY cycles after acceptance.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_width,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int unsigned    AW        = $clog2(DEPTH_WORDS);
    localparam logic [29:0]    DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    resp_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_done_q;

    logic [AW-1:0]    idx_q;
    logic [1:0]       off_q;
    mem_width_e       width_q;
    logic             uns_q;
    logic             write_q;
    logic             err_q;
    logic [31:0]      rdata_q;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      mem_word;
    logic [31:0]      load_result;

    mem_width_e       req_width_e;
    logic [AW-1:0]    req_idx;
    logic             req_err;
    logic             accept;
    logic             load_fire;
    logic [3:0]       store_be;
    logic [31:0]      store_data;

    assign req_width_e = mem_width_e'(req_width);
    assign req_idx     = req_addr[AW+1:2];
    assign req_err     = is_misaligned(req_width_e, req_addr[1:0]) ||
                         (req_addr[31:2] >= DEPTH_LIM);
    assign req_ready   = rst_done_q && (state_q == ST_IDLE);
    assign accept      = req_valid && req_ready;
    assign load_fire   = (state_q == ST_WAIT) && (cnt_q == '0);

    assign resp_valid  = (state_q == ST_RESP);
    assign resp_error  = resp_valid && err_q;
    assign resp_rdata  = resp_valid ? rdata_q : 32'h0;

    // State register, latency counter and the post-reset ready enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rst_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_done_q <= 1'b1;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the request at acceptance and the load result at WAIT->RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            off_q   <= '0;
            width_q <= MEM_WIDTH_BYTE;
            uns_q   <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                idx_q   <= req_idx;
                off_q   <= req_addr[1:0];
                width_q <= req_width_e;
                uns_q   <= req_unsigned;
                write_q <= req_write;
                err_q   <= req_err;
            end
            if (load_fire) begin
                rdata_q <= (write_q || err_q) ? 32'h0 : load_result;
            end
        end
    end

    // Replicate store data across lanes and enable only the addressed bytes.
    always_comb begin
        case (req_width_e)
            MEM_WIDTH_BYTE: begin
                store_be   = 4'b0001 << req_addr[1:0];
                store_data = {4{req_wdata[7:0]}};
            end
            MEM_WIDTH_HALF: begin
                store_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{req_wdata[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = req_wdata;
            end
        endcase
    end

    // Store commit on the acceptance edge; erroring stores leave memory intact.
    // NOTE: the array has no reset; contents survive rst like a real RAM.
    always_ff @(posedge clk) begin
        if (accept && req_write && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (store_be[b]) mem[req_idx][8*b +: 8] <= store_data[8*b +: 8];
            end
        end
    end

    assign mem_word = mem[idx_q];

    mem_lane_extract u_lane_extract (
        .word        (mem_word),
        .byte_off    (off_q),
        .width       (width_q),
        .is_unsigned (uns_q),
        .result      (load_result)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder (DEPTH_WORDS=1024, LATENCY=2).
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int unsigned LAT = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_width;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb[$];

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_width    (req_width),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for req_ready at a negedge, drive one request.
    task automatic drive_req(input string tag, input logic wr, input mem_width_e w,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, 32'(n < 50), 32'd1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_width    = logic'(w[1:0]) == 1'b0 ? w : w;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
    endtask

    // Full transaction: accept, check latency, optionally stall, compare, release.
    task automatic do_req(input string tag, input logic wr, input mem_width_e w,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int   k;
        exp_t e;
        drive_req(tag, wr, w, uns, addr, wdata);
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!resp_valid && k < 20) begin
            check({tag, "_rdata_idle"}, resp_rdata, 32'h0);
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, 32'(k), 32'(LAT));
        for (int h = 0; h < hold; h++) begin
            check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, "_hold_rdata"}, resp_rdata, sb[0].rdata);
            check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        e = sb.pop_front();
        check({tag, "_rdata"}, resp_rdata, e.rdata);
        check({tag, "_error"}, 32'(resp_error), 32'(e.err));
        check({tag, "_busy"}, 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
        check({tag, "_valid_after"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_width    = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        resp_ready   = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_req_ready",  32'(req_ready),  32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata,      32'h0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Word store/load.
        do_req("st_w10",  1'b1, MEM_WIDTH_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0);
        do_req("ld_w10",  1'b0, MEM_WIDTH_WORD, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 0);

        // Byte lane store, signed/unsigned loads, merged word.
        do_req("st_b13",  1'b1, MEM_WIDTH_BYTE, 1'b0, 32'h13, 32'h00000080, 32'h0,        1'b0, 0);
        do_req("ld_bs13", 1'b0, MEM_WIDTH_BYTE, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 0);
        do_req("ld_bu13", 1'b0, MEM_WIDTH_BYTE, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0, 0);
        do_req("ld_w10b", 1'b0, MEM_WIDTH_WORD, 1'b0, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 0);
        do_req("ld_bs12", 1'b0, MEM_WIDTH_BYTE, 1'b0, 32'h12, 32'h0,        32'hFFFFFFAD, 1'b0, 0);
        do_req("ld_hs12", 1'b0, MEM_WIDTH_HALF, 1'b0, 32'h12, 32'h0,        32'hFFFF80AD, 1'b0, 0);
        do_req("ld_hu10", 1'b0, MEM_WIDTH_HALF, 1'b1, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, 0);

        // Misalignment.
        do_req("ld_h11",  1'b0, MEM_WIDTH_HALF, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 0);
        do_req("st_w14",  1'b1, MEM_WIDTH_WORD, 1'b0, 32'h14, 32'h11223344, 32'h0,        1'b0, 0);
        do_req("st_w16",  1'b1, MEM_WIDTH_WORD, 1'b0, 32'h16, 32'hFFFFFFFF, 32'h0,        1'b1, 0);
        do_req("ld_w14",  1'b0, MEM_WIDTH_WORD, 1'b0, 32'h14, 32'h0,        32'h11223344, 1'b0, 0);
        do_req("st_h16",  1'b1, MEM_WIDTH_HALF, 1'b0, 32'h16, 32'h0000A5A5, 32'h0,        1'b0, 0);
        do_req("ld_w14b", 1'b0, MEM_WIDTH_WORD, 1'b0, 32'h14, 32'h0,        32'hA5A53344, 1'b0, 0);
        do_req("ld_hu16", 1'b0, MEM_WIDTH_HALF, 1'b1, 32'h16, 32'h0,        32'h0000A5A5, 1'b0, 0);

        // Out-of-range, including a store that would alias onto word 0.
        do_req("st_w0",   1'b1, MEM_WIDTH_WORD, 1'b0, 32'h0,    32'h00000055, 32'h0,        1'b0, 0);
        do_req("st_w1000",1'b1, MEM_WIDTH_WORD, 1'b0, 32'h1000, 32'hAAAAAAAA, 32'h0,        1'b1, 0);
        do_req("ld_w1000",1'b0, MEM_WIDTH_WORD, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1, 0);
        do_req("ld_w0",   1'b0, MEM_WIDTH_WORD, 1'b0, 32'h0,    32'h0,        32'h00000055, 1'b0, 0);
        do_req("st_wffc", 1'b1, MEM_WIDTH_WORD, 1'b0, 32'hFFC,  32'h0BADF00D, 32'h0,        1'b0, 0);
        do_req("ld_wffc", 1'b0, MEM_WIDTH_WORD, 1'b0, 32'hFFC,  32'h0,        32'h0BADF00D, 1'b0, 0);

        // Back-pressure: response held for 5 cycles.
        do_req("ld_hold", 1'b0, MEM_WIDTH_WORD, 1'b0, 32'h10,   32'h0,        32'h80ADBEEF, 1'b0, 5);

        // Reset during WAIT of a load: no response, prior store survives.
        do_req("st_w20",  1'b1, MEM_WIDTH_WORD, 1'b0, 32'h20,   32'hCAFEF00D, 32'h0,        1'b0, 0);
        drive_req("ld_abort", 1'b0, MEM_WIDTH_WORD, 1'b0, 32'h20, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_rst_valid", 32'(resp_valid), 32'd0);
        check("abort_rst_ready", 32'(req_ready),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        do_req("ld_w20",  1'b0, MEM_WIDTH_WORD, 1'b0, 32'h20,   32'h0,        32'hCAFEF00D, 1'b0, 0);

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
